// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped peripheral window with LEDs, switches, a multiplexed
// seven-segment display, a keyboard scan-code FIFO and a free-running cycle counter.
`default_nettype none

module mmio_hub #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          LED_W      = 16,
  parameter int          SW_W       = 16,
  parameter int          HEX_DIGITS = 8,
  parameter int          KBD_DEPTH  = 16,
  parameter int          SCAN_DIV   = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [2:0]            memop,
  input  logic                  we,
  input  logic                  rd_en,
  output logic [31:0]           rdata,
  output logic                  hit,
  input  logic [SW_W-1:0]       sw,
  input  logic [7:0]            kbd_code,
  input  logic                  kbd_valid,
  output logic [LED_W-1:0]      led,
  output logic [HEX_DIGITS-1:0] an,
  output logic [7:0]            seg
);

  localparam int KAW = $clog2(KBD_DEPTH);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int DIW = (HEX_DIGITS > 1) ? $clog2(HEX_DIGITS) : 1;

  localparam logic [KAW:0]   KBD_FULL  = (KAW+1)'(KBD_DEPTH);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [DIW-1:0] DIG_LAST  = DIW'(HEX_DIGITS - 1);

  localparam logic [5:0] OFF_LED  = 6'h00;
  localparam logic [5:0] OFF_SW   = 6'h01;
  localparam logic [5:0] OFF_HEX  = 6'h02;
  localparam logic [5:0] OFF_HEN  = 6'h03;
  localparam logic [5:0] OFF_KDAT = 6'h04;
  localparam logic [5:0] OFF_KST  = 6'h05;
  localparam logic [5:0] OFF_CYC  = 6'h06;

  logic [4*HEX_DIGITS-1:0] hex_val;
  logic [HEX_DIGITS-1:0]   hex_en;
  logic [SW_W-1:0]         sw_meta, sw_sync;
  logic [31:0]             cycle_cnt;
  logic [7:0]              kbd_mem [KBD_DEPTH];
  logic [KAW-1:0]          rd_ptr, wr_ptr;
  logic [KAW:0]            count;
  logic                    ovf;
  logic [SCW-1:0]          scan_cnt;
  logic [DIW-1:0]          digit;

  logic [5:0]  reg_sel;
  logic        store, load, kbd_empty, kbd_full, pop, push_ok, ovf_evt;
  logic [31:0] rd_word, wr_mask, wr_data, merged, load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign hit       = (addr[31:8] == BASE_ADDR[31:8]);
  assign reg_sel   = addr[7:2];
  assign store     = we & hit;
  assign load      = rd_en & hit;
  assign kbd_empty = (count == '0);
  assign kbd_full  = (count == KBD_FULL);
  assign pop       = load & (reg_sel == OFF_KDAT) & ~kbd_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
  assign push_ok   = kbd_valid & (~kbd_full | pop);
  assign ovf_evt   = kbd_valid & kbd_full & ~pop;

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      OFF_LED:  rd_word[LED_W-1:0]        = led;
      OFF_SW:   rd_word[SW_W-1:0]         = sw_sync;
      OFF_HEX:  rd_word[4*HEX_DIGITS-1:0] = hex_val;
      OFF_HEN:  rd_word[HEX_DIGITS-1:0]   = hex_en;
      OFF_KDAT: if (!kbd_empty) rd_word[8:0] = {1'b1, kbd_mem[rd_ptr]};
      OFF_KST: begin
        rd_word[31]    = ovf;
        rd_word[KAW:0] = count;
      end
      OFF_CYC:  rd_word = cycle_cnt;
      default:  rd_word = '0;
    endcase
  end

  always_comb begin
    wr_mask = 32'hFFFF_FFFF;
    wr_data = wdata;
    case (memop[1:0])
      2'b00: begin
        wr_mask = 32'h0000_00FF << {addr[1:0], 3'b000};
        wr_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        wr_mask = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wr_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Partial stores merge into the current register contents through the read mux.
  assign merged   = (rd_word & ~wr_mask) | (wr_data & wr_mask);
  assign byte_sel = rd_word[{addr[1:0], 3'b000} +: 8];
  assign half_sel = rd_word[{addr[1], 4'b0000} +: 16];

  always_comb begin
    case (memop)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = rd_word;
    endcase
  end

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = ~7'h3F;  4'h1: font = ~7'h06;  4'h2: font = ~7'h5B;  4'h3: font = ~7'h4F;
      4'h4: font = ~7'h66;  4'h5: font = ~7'h6D;  4'h6: font = ~7'h7D;  4'h7: font = ~7'h07;
      4'h8: font = ~7'h7F;  4'h9: font = ~7'h6F;  4'hA: font = ~7'h77;  4'hB: font = ~7'h7C;
      4'hC: font = ~7'h39;  4'hD: font = ~7'h5E;  4'hE: font = ~7'h79;  default: font = ~7'h71;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led       <= '0;
      hex_val   <= '0;
      hex_en    <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      cycle_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      rdata     <= '0;
      scan_cnt  <= '0;
      digit     <= '0;
      an        <= '1;
      seg       <= 8'hFF;
    end else begin
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      cycle_cnt <= cycle_cnt + 32'd1;

      if (load) rdata <= load_val;

      if (store) begin
        case (reg_sel)
          OFF_LED: led     <= merged[LED_W-1:0];
          OFF_HEX: hex_val <= merged[4*HEX_DIGITS-1:0];
          OFF_HEN: hex_en  <= merged[HEX_DIGITS-1:0];
          default: ;
        endcase
      end

      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      // An overflow in the same cycle as a clearing store wins.
      if (ovf_evt)
        ovf <= 1'b1;
      else if (store && reg_sel == OFF_KST)
        ovf <= 1'b0;

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        digit    <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      an  <= hex_en[digit] ? ~(HEX_DIGITS'(1) << digit) : '1;
      seg <= {1'b1, font(hex_val[{digit, 2'b00} +: 4])};
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) kbd_mem[wr_ptr] <= kbd_code;
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: randomized register/FIFO traffic against a behavioural model,
// plus directed display-scan and reset scenarios.
`default_nettype none

module tb_mmio_hub;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          LED_W = 16;
  localparam int          SW_W  = 16;
  localparam int          HD    = 8;
  localparam int          KD    = 16;
  localparam int          SD    = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       addr, wdata, rdata;
  logic [2:0]        memop;
  logic              we, rd_en, hit;
  logic [SW_W-1:0]   sw;
  logic [7:0]        kbd_code;
  logic              kbd_valid;
  logic [LED_W-1:0]  led;
  logic [HD-1:0]     an;
  logic [7:0]        seg;

  mmio_hub #(
    .BASE_ADDR(BASE), .LED_W(LED_W), .SW_W(SW_W), .HEX_DIGITS(HD),
    .KBD_DEPTH(KD), .SCAN_DIV(SD)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .memop(memop),
    .we(we), .rd_en(rd_en), .rdata(rdata), .hit(hit), .sw(sw),
    .kbd_code(kbd_code), .kbd_valid(kbd_valid), .led(led), .an(an), .seg(seg)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic [31:0] m_led, m_hex, m_en, m_sw, m_rdata;
  bit          m_rdata_known, m_ovf;
  logic [7:0]  m_q[$];
  logic [31:0] junk;

  task automatic model_reset();
    m_led = 0; m_hex = 0; m_en = 0; m_rdata = 0; m_rdata_known = 1; m_ovf = 0;
    m_q.delete();
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] off);
    case (off)
      8'h00: return m_led;
      8'h04: return m_sw;
      8'h08: return m_hex;
      8'h0C: return m_en;
      8'h10: return (m_q.size() != 0) ? (32'h100 + 32'(m_q[0])) : 32'h0;
      8'h14: return (m_ovf ? 32'h8000_0000 : 32'h0) + 32'(m_q.size());
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] lane, input logic [2:0] mop);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> (8 * int'(lane)));
    h = 16'(word >> (16 * int'(lane[1])));
    case (mop)
      3'b000:  return (b >= 8'h80) ? (32'hFFFF_FF00 + 32'(b)) : 32'(b);
      3'b100:  return 32'(b);
      3'b001:  return (h >= 16'h8000) ? (32'hFFFF_0000 + 32'(h)) : 32'(h);
      3'b101:  return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [1:0] lane,
                                              input logic [2:0] mop, input logic [31:0] wd);
    logic [31:0] r;
    bit          sel;
    logic [7:0]  src;
    r = old;
    for (int i = 0; i < 4; i++) begin
      case (mop[1:0])
        2'b00:   begin sel = (i == int'(lane));     src = wd[7:0]; end
        2'b01:   begin sel = (i / 2 == int'(lane[1])); src = wd[8*(i%2) +: 8]; end
        default: begin sel = 1'b1;                  src = wd[8*i +: 8]; end
      endcase
      if (sel) r[8*i +: 8] = src;
    end
    return r;
  endfunction

  // One bus cycle: drive, clock, compare any load against the model, then update the model.
  task automatic cyc(input bit wr, input bit rd, input logic [31:0] a, input logic [2:0] mop,
                     input logic [31:0] wd, input bit kv, input logic [7:0] kc,
                     input string tag, output logic [31:0] got);
    bit          h, do_pop, ovf_evt;
    logic [7:0]  off;
    logic [31:0] exp;
    h   = (a[31:8] == BASE[31:8]);
    off = a[7:0] & 8'hFC;
    addr = a; wdata = wd; memop = mop; we = wr; rd_en = rd; kbd_valid = kv; kbd_code = kc;
    #1;
    if (rd) check({tag, "/hit"}, {31'b0, hit}, {31'b0, h});
    exp     = (rd && h) ? extend(model_word(off), a[1:0], mop) : m_rdata;
    do_pop  = rd && h && off == 8'h10 && m_q.size() != 0;
    ovf_evt = kv && m_q.size() == KD && !do_pop;
    @(posedge clock);
    #1;
    we = 1'b0; rd_en = 1'b0; kbd_valid = 1'b0;
    got = rdata;
    if (rd && h && off == 8'h18) m_rdata_known = 0;
    else if (rd && (h || m_rdata_known)) begin
      check(tag, rdata, exp);
      m_rdata = exp;
      m_rdata_known = 1;
    end
    if (do_pop) void'(m_q.pop_front());
    if (kv && !ovf_evt) m_q.push_back(kc);
    if (ovf_evt) m_ovf = 1;
    else if (wr && h && off == 8'h14) m_ovf = 0;
    if (wr && h) begin
      case (off)
        8'h00: m_led = merge_store(m_led, a[1:0], mop, wd) & 32'h0000_FFFF;
        8'h08: m_hex = merge_store(m_hex, a[1:0], mop, wd);
        8'h0C: m_en  = merge_store(m_en,  a[1:0], mop, wd) & 32'h0000_00FF;
        default: ;
      endcase
    end
  endtask

  task automatic st(input logic [7:0] off, input logic [2:0] mop, input logic [31:0] wd);
    cyc(1, 0, BASE | 32'(off), mop, wd, 0, 8'h0, "store", junk);
  endtask

  task automatic ld(input logic [7:0] off, input logic [2:0] mop, input string tag, output logic [31:0] got);
    cyc(0, 1, BASE | 32'(off), mop, 32'h0, 0, 8'h0, tag, got);
  endtask

  task automatic push(input logic [7:0] code);
    cyc(0, 0, 32'h0, 3'b010, 32'h0, 1, code, "push", junk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 3'b010, 32'h0, 0, 8'h0, "idle", junk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, c1, c2;
    logic [7:0]  offs[8];
    logic [2:0]  mops[5];
    bit          found;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h1C, 8'hFC};
    mops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    reset = 1'b1; addr = 0; wdata = 0; memop = 0; we = 0; rd_en = 0;
    kbd_code = 0; kbd_valid = 0; sw = 16'h5A3C;
    model_reset();
    m_sw = 32'h5A3C;
    repeat (3) @(posedge clock);
    #1;
    check("rst/an", 32'(an), 32'h0000_00FF);
    check("rst/seg", 32'(seg), 32'h0000_00FF);
    check("rst/led", 32'(led), 32'h0);
    check("rst/rdata", rdata, 32'h0);
    #2 reset = 1'b0;
    #1;

    // Counter reads 0 at the first edge after release, and advances one per clock.
    ld(8'h18, 3'b010, "cyc0", c1);
    check("cyc/first", c1, 32'h0);
    idle(5);
    ld(8'h18, 3'b010, "cyc1", c2);
    check("cyc/delta", c2 - c1, 32'd6);

    ld(8'h00, 3'b010, "rst/led_rd", got);
    ld(8'h14, 3'b010, "rst/kst_rd", got);
    ld(8'h04, 3'b010, "sw_rd", got);

    sw = 16'hC3E1;
    idle(2);
    m_sw = 32'hC3E1;
    ld(8'h04, 3'b010, "sw_sync", got);

    // LED partial stores and signed byte load
    st(8'h00, 3'b010, 32'h1234_5678);
    st(8'h01, 3'b000, 32'h0000_00AB);
    ld(8'h00, 3'b010, "led_word", got);
    check("led_word_k", got, 32'h0000_AB78);
    check("led_port", 32'(led), 32'h0000_AB78);
    ld(8'h01, 3'b000, "led_lb", got);
    check("led_lb_k", got, 32'hFFFF_FFAB);

    // Basic keyboard push/pop
    push(8'h1C);
    push(8'h32);
    ld(8'h10, 3'b010, "kbd_pop1", got);  check("kbd_pop1_k", got, 32'h11C);
    ld(8'h10, 3'b010, "kbd_pop2", got);  check("kbd_pop2_k", got, 32'h132);
    ld(8'h10, 3'b010, "kbd_pop3", got);  check("kbd_pop3_k", got, 32'h0);
    ld(8'h14, 3'b010, "kbd_st0", got);   check("kbd_st0_k", got, 32'h0);

    // Overflow, clear, then full-FIFO pop+push
    for (int i = 0; i <= KD; i++) push(8'h40 + 8'(i));
    ld(8'h14, 3'b010, "ovf_st", got);    check("ovf_st_k", got, 32'h8000_0010);
    st(8'h14, 3'b010, 32'h0);
    ld(8'h14, 3'b010, "ovf_clr", got);   check("ovf_clr_k", got, 32'h0000_0010);
    cyc(0, 1, BASE | 32'h10, 3'b010, 32'h0, 1, 8'h99, "full_pp", got);
    check("full_pp_k", got, 32'h140);
    ld(8'h14, 3'b010, "full_pp_st", got); check("full_pp_st_k", got, 32'h0000_0010);
    for (int i = 0; i < KD; i++) ld(8'h10, 3'b010, "drain", got);
    check("drain_last", got, 32'h199);
    // Empty FIFO with pop+push: read returns 0, code is kept
    cyc(0, 1, BASE | 32'h10, 3'b010, 32'h0, 1, 8'h77, "empty_pp", got);
    check("empty_pp_k", got, 32'h0);
    ld(8'h10, 3'b010, "empty_pp_pop", got);

    // Clear overflow in the same cycle as a new overflow event: it stays set
    for (int i = 0; i < KD; i++) push(8'(i));
    cyc(1, 0, BASE | 32'h14, 3'b010, 32'h0, 1, 8'hEE, "ovf_race", junk);
    ld(8'h14, 3'b010, "ovf_race_st", got); check("ovf_race_k", got, 32'h8000_0010);

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      int          r;
      bit          kv;
      logic [7:0]  kc, off;
      logic [2:0]  mop;
      logic [1:0]  lane;
      r    = int'($urandom_range(0, 99));
      kv   = ($urandom_range(0, 3) == 0);
      kc   = 8'($urandom);
      mop  = mops[$urandom_range(0, 4)];
      lane = (mop[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) :
             (mop[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      if (r < 35) begin
        case ($urandom_range(0, 9))
          0, 1, 2: off = 8'h00;
          3, 4:    off = 8'h08;
          5:       off = 8'h0C;
          6:       off = 8'h14;
          7:       off = 8'h04;
          8:       off = 8'h10;
          default: off = 8'h24;
        endcase
        cyc(1, 0, BASE | 32'(off | 8'(lane)), mop, $urandom, kv, kc, "rnd_st", junk);
      end else if (r < 85) begin
        off = offs[$urandom_range(0, 7)];
        cyc(0, 1, BASE | 32'(off | 8'(lane)), mop, 32'h0, kv, kc, "rnd_ld", junk);
      end else if (r < 92) begin
        off = offs[$urandom_range(0, 7)];
        cyc(0, 1, 32'h1234_5600 | 32'(off), 3'b010, 32'h0, kv, kc, "rnd_miss_ld", junk);
      end else if (r < 96) begin
        cyc(1, 0, 32'hFFFE_0000, 3'b010, $urandom, kv, kc, "rnd_miss_st", junk);
      end else begin
        cyc(0, 0, 32'h0, 3'b010, 32'h0, kv, kc, "rnd_idle", junk);
      end
    end
    ld(8'h00, 3'b010, "rnd_led_final", got);
    ld(8'h08, 3'b010, "rnd_hex_final", got);
    ld(8'h14, 3'b010, "rnd_kst_final", got);

    // Display scan: only digit 0 enabled, showing 5
    st(8'h08, 3'b010, 32'h0000_00A5);
    st(8'h0C, 3'b010, 32'h0000_0001);
    idle(1);
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (an == 8'hFF) found = 1; else begin @(posedge clock); #1; end
    end
    check("scan_wait_off", {31'b0, found}, 32'h1);
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (an == 8'hFE) found = 1; else begin @(posedge clock); #1; end
    end
    check("scan_wait_on", {31'b0, found}, 32'h1);
    for (int k = 0; k < 36; k++) begin
      check("scan_an", 32'(an), ((k % 32) < 4) ? 32'hFE : 32'hFF);
      if ((k % 32) < 4) check("scan_seg", 32'(seg), 32'h92);
      @(posedge clock); #1;
    end

    // Reset asserted in the middle of a pop with three entries queued
    push(8'h11); push(8'h22); push(8'h33);
    addr = BASE | 32'h10; memop = 3'b010; rd_en = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mid_rst/rdata", rdata, 32'h0);
    check("mid_rst/an", 32'(an), 32'hFF);
    check("mid_rst/seg", 32'(seg), 32'hFF);
    check("mid_rst/led", 32'(led), 32'h0);
    @(posedge clock); #1;
    rd_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    ld(8'h14, 3'b010, "post_rst_st", got);   check("post_rst_st_k", got, 32'h0);
    ld(8'h10, 3'b010, "post_rst_pop", got);  check("post_rst_pop_k", got, 32'h0);
    ld(8'h08, 3'b010, "post_rst_hex", got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 SHALL have parameters: BASE_ADDR, default 32'hFFFF_0000, peripheral window base (low 8 bits ignored); LED_W, default 16, LED register width (1..32); SW_W, default 16, switch input width (1..32); HEX_DIGITS, default 8, seven-segment digit count (1..8); KBD_DEPTH, default 16, keyboard FIFO depth (power of 2, >=2); SCAN_DIV, default 50000, clock cycles per display digit slot (>=2).
REQ-002 SHALL have ports, in this order:
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- addr  in  32  CPU data address
- wdata  in  32  CPU store data
- memop  in  3  000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned
- we  in  1  store strobe
- rd_en  in  1  load strobe
- rdata  out  32  load data, registered
- hit  out  1  combinational: addr[31:8]==BASE_ADDR[31:8]
- sw  in  SW_W  raw switches
- kbd_code  in  8  scan code from PS/2 receiver
- kbd_valid  in  1  one-cycle push strobe for kbd_code
- led  out  LED_W  LED register
- an  out  HEX_DIGITS  digit selects, active-low
- seg  out  8  segments {dp,g..a}, active-low

Function
REQ-003 Offsets addr[7:0]: 0x00 LED RW; 0x04 SW RO; 0x08 HEX value RW (nibble i = digit i); 0x0C HEX enable RW (bits [HEX_DIGITS-1:0]); 0x10 KBD data RO-pop; 0x14 KBD status (read: bit31 overflow, bits[7:0] count; write: any value clears overflow); 0x18 cycle counter RO.
REQ-004 Store SHALL take effect at the posedge where we&hit; byte/half stores update only lanes selected by addr[1:0] (half uses addr[1]); word store ignores addr[1:0].
REQ-005 Unlisted offsets SHALL read 0; stores to them and to RO registers (except 0x14) SHALL be ignored; register bits beyond implemented width read 0.
REQ-006 Load: at posedge with rd_en&hit, rdata SHALL capture the addressed word shifted by addr[1:0] and sign/zero-extended per memop; rdata holds otherwise (latency 1 cycle).
REQ-007 sw SHALL pass through a 2-flop synchroniser; 0x04 returns the synchronised value.
REQ-008 Cycle counter SHALL increment by 1 every clock, wrapping 32'hFFFF_FFFF -> 0.
REQ-009 Keyboard FIFO: push when kbd_valid; pop when rd_en&hit&offset 0x10 and not empty; pop-read returns {23'b0, 1'b1, code}; read when empty returns 0 and does not change state.
REQ-010 Full and push without pop SHALL drop the code and set sticky overflow; full with simultaneous pop+push SHALL accept the push; empty with simultaneous pop+push SHALL return 0 and store the code.
REQ-011 Count SHALL equal stored entries (0..KBD_DEPTH); pointers wrap modulo KBD_DEPTH.
REQ-012 Store to 0x14 in the same cycle as an overflow event SHALL leave overflow set.
REQ-013 Scanner: counter 0..SCAN_DIV-1; at SCAN_DIV-1 counter returns to 0 and digit index advances, wrapping HEX_DIGITS-1 -> 0.
REQ-014 an SHALL be the active-low one-hot of the digit index when that digit's enable bit is 1, else all ones; seg SHALL be the active-low hex font (0-F) of that nibble with dp=1; all registered.

Reset
REQ-015 Asserting reset SHALL immediately clear: led, HEX value, HEX enable, FIFO pointers/count, overflow, cycle counter, scan counter, digit index, rdata=0, synchroniser flops=0; an SHALL be all ones, seg 8'hFF.
REQ-016 Reset mid-operation SHALL discard FIFO contents and any in-flight load; first post-reset load returns post-reset values.

Verification
REQ-017 Word store 0x12345678 to BASE+0x00, then byte store 0xAB at BASE+0x01 -> LED_W=16 reads 0xAB78; lb at BASE+0x01 -> 0xFFFFFFAB one cycle after rd_en.
REQ-018 Push 0x1C,0x32 then two pops from 0x10 -> 0x11C, 0x132; third pop -> 0; status count 0.
REQ-019 Push KBD_DEPTH+1 codes -> count=KBD_DEPTH, status bit31=1, last code absent; store to 0x14 -> bit31=0.
REQ-020 Full FIFO, pop and push same cycle -> count stays KBD_DEPTH, overflow stays 0, new code last out.
REQ-021 HEX=0x0000_00A5, enable=0x01, SCAN_DIV=4 -> an=8'hFE with seg=font(5) for 4 cycles, then an=8'hFF for 28 cycles, repeating.
REQ-022 Reset asserted mid-pop with 3 entries -> count 0, rdata 0, an all ones asynchronously.
